pipeline_skid_fifo: RTL and testbench
=====================================

# pipeline_skid_fifo

Elastic buffer that sits between two pipeline stages using the valid/allow handshake. It cuts the backward (allow) combinational path that a plain pipeline register forwards from `allow_out` to `allow_in`. Examples are between IF and ID so the instruction-RAM response can be absorbed while decode stalls. It stores up to `DEPTH` entries in order and offers a synchronous flush for branch/exception kill.

## Interface
- `WIDTH`, 32: payload width in bits.
- `DEPTH`, 2: entry count; power of two, ≥ 2.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `valid_in`  in  1  upstream offers `in` this cycle.
- `allow_in`  out  1  buffer can accept an entry this cycle.
- `in`  in  WIDTH  upstream payload.
- `valid_out`  out  1  `out` holds a valid entry.
- `allow_out`  in  1  downstream accepts `out` this cycle.
- `out`  out  WIDTH  head entry payload.
- `flush`  in  1  discard all entries (synchronous).
- `level`  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Push: `valid_in && allow_in` → `in` written at `wr_ptr`, `wr_ptr` += 1 mod DEPTH.
- Pop: `valid_out && allow_out` → `rd_ptr` += 1 mod DEPTH.
- `level` next = `level` + push − pop. Simultaneous push and pop leave `level` unchanged, and both pointers advance.
- `allow_in` = (`level` != DEPTH). It is a function of registered state only, with no combinational dependence on `allow_out`, `valid_in` or `flush`.
- `valid_out` = (`level` != 0), from registered state only.
- `out` = storage[`rd_ptr`]. The value is unspecified while `valid_out` = 0.
- Full (`level` = DEPTH):
  - `allow_in` = 0, so no push occurs even if a pop happens that cycle.
  - Space becomes visible the following cycle.
- Empty (`level` = 0):
  - `valid_out` = 0, and there is no same-cycle bypass from `in` to `out`.
  - A pushed entry appears on `out` the next cycle.
- Pointer wrap: `rd_ptr`/`wr_ptr` are clog2(DEPTH) bits wide and wrap naturally. Full and empty are distinguished by `level`, not by pointer compare.
- `flush`:
  - Next cycle `level` = 0, `rd_ptr` = `wr_ptr` = 0.
  - Any push or pop in the flush cycle is ignored. The flush wins over both, and an upstream handshake that cycle is treated as dropped.
- `reset` has priority over `flush` and all handshakes. It clears `level`, `rd_ptr` and `wr_ptr`. Storage contents are not reset.
- Payload ordering is strict FIFO, with no entry duplicated or dropped except by `flush`/`reset`.

## Timing
- Reset values:
  - `valid_out` = 0
  - `allow_in` = 1
  - `level` = 0
  - `out` unspecified
- Outputs are valid one cycle after `reset` deasserts. `allow_in` = 1 is driven during the reset cycle, but pushes in that cycle are discarded.
- Latency from push to `valid_out` is 1 cycle.
- Throughput is 1 entry/cycle sustained when `allow_out` = 1 and `level` is between 1 and DEPTH−1.
- With DEPTH = 2, full throughput holds with stalls, because one entry can be taken while one is emitted.
- Reset or flush mid-stream: all entries vanish at the next edge. Entries pushed from the cycle after reset or flush onward are retained normally.
- `allow_out` may toggle freely. When `allow_out` = 0, `out` and `valid_out` are held stable.
- `in` is sampled only on push cycles.

## Test plan
- Reset, then push A=0x11 with `allow_out`=1:
  - Cycle 1: `valid_out`=1, `out`=0x11.
  - Cycle 2: `valid_out`=0, `level`=0.
- Hold `allow_out`=0 and push 0x1, 0x2 (DEPTH=2):
  - `allow_in` drops to 0 after the second push and `level`=2.
  - A third `valid_in` with 0x3 is not accepted.
  - Raising `allow_out` yields 0x1, then 0x2, then 0x3 once re-offered.
- Continuous push of 0..15 with `allow_out`=1 every cycle:
  - `out` sequence is 0..15 with one output per cycle after the first.
  - `level` stays at 1, and pointers wrap at least 4 times without loss.
- Random `valid_in`/`allow_out` (50%) over 10k cycles against a reference queue:
  - Order and data always match.
  - `level` equals the model count.
  - `allow_in` never depends on same-cycle `allow_out` (checked by toggling `allow_out` mid-cycle in simulation).
- Fill with 2 entries, then assert `flush` together with `valid_in`=1 (0xAA) and `allow_out`=1:
  - Next cycle `level`=0 and `valid_out`=0.
  - 0xAA is never emitted.
  - A push on the following cycle is emitted normally.
- Assert `reset` while `level`=2 with `valid_in`=1:
  - Next cycle `level`=0, `valid_out`=0, `allow_in`=1.
  - No pre-reset data is emitted afterward.

Source files
------------

// File: rtl/pipeline_skid_fifo.sv
// pipeline_skid_fifo: elastic valid/allow buffer between two pipeline stages.
// allow_in and valid_out come from registered occupancy only, cutting the backward path.
module pipeline_skid_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  output logic                     allow_in,
  input  logic [WIDTH-1:0]         in,
  output logic                     valid_out,
  input  logic                     allow_out,
  output logic [WIDTH-1:0]         out,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             push;
  logic             pop;

  assign allow_in  = (level != FULL);
  assign valid_out = (level != '0);
  assign out       = mem[rd_ptr];

  // handshakes; a flush kills both sides of the transfer
  always_comb begin
    push = valid_in && allow_in && !flush;
    pop  = valid_out && allow_out && !flush;
  end

  // occupancy and pointers; reset beats flush beats handshakes
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      level  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // payload storage, intentionally not reset
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= in;
  end

endmodule

// File: tb/tb_pipeline_skid_fifo.sv
// tb_pipeline_skid_fifo: scoreboard bench for pipeline_skid_fifo.
// Inputs change #1 after posedge; outputs are inspected mid-cycle.
module tb_pipeline_skid_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int LW = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             valid_in = 1'b0;
  logic             allow_in;
  logic [WIDTH-1:0] in = '0;
  logic             valid_out;
  logic             allow_out = 1'b0;
  logic [WIDTH-1:0] out;
  logic             flush = 1'b0;
  logic [LW-1:0]    level;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] q[$];

  pipeline_skid_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .valid_in(valid_in), .allow_in(allow_in), .in(in),
    .valid_out(valid_out), .allow_out(allow_out), .out(out),
    .flush(flush), .level(level)
  );

  always #5 clk = ~clk;

  // advance one clock, updating the reference queue from the driven stimulus
  task automatic tick();
    bit pu;
    bit po;
    @(negedge clk);
    pu = valid_in && (q.size() != DEPTH);
    po = (q.size() != 0) && allow_out;
    if (reset || flush) begin
      q.delete();
    end else begin
      if (po) void'(q.pop_front());
      if (pu) q.push_back(in);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    valid_in = 1'b1;
    in = 32'hDEAD;
    tick();
    checks++;
    if (allow_in !== 1'b1)
      $display("FAIL reset_allow_in: got %b want 1", allow_in);
    else ;
    if (allow_in !== 1'b1) errors++;
    tick();
    reset = 1'b0;
    valid_in = 1'b0;
    checks++;
    if (valid_out !== 1'b0 || level !== '0 || allow_in !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid_out=%b level=%0d allow_in=%b want 0 0 1",
               valid_out, level, allow_in);
    end
  endtask

  task automatic test_single();
    allow_out = 1'b1;
    valid_in = 1'b1;
    in = 32'h11;
    tick();
    valid_in = 1'b0;
    checks++;
    if (valid_out !== 1'b1 || out !== 32'h11) begin
      errors++;
      $display("FAIL single_out: valid_out=%b out=%h want 1 11", valid_out, out);
    end
    tick();
    checks++;
    if (valid_out !== 1'b0 || level !== '0) begin
      errors++;
      $display("FAIL single_drain: valid_out=%b level=%0d want 0 0", valid_out, level);
    end
  endtask

  task automatic test_full();
    logic [WIDTH-1:0] seen[$];
    allow_out = 1'b0;
    valid_in = 1'b1;
    in = 32'h1;
    tick();
    in = 32'h2;
    tick();
    checks++;
    if (allow_in !== 1'b0 || level !== LW'(2)) begin
      errors++;
      $display("FAIL full_state: allow_in=%b level=%0d want 0 2", allow_in, level);
    end
    in = 32'h3;
    tick();
    checks++;
    if (level !== LW'(2) || q.size() != 2) begin
      errors++;
      $display("FAIL full_reject: level=%0d want 2", level);
    end
    allow_out = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (valid_out && allow_out) seen.push_back(out);
      if (i == 2) valid_in = 1'b0;
      tick();
    end
    checks++;
    if (seen.size() != 3 || seen[0] !== 32'h1 || seen[1] !== 32'h2 ||
        seen[2] !== 32'h3) begin
      errors++;
      $display("FAIL full_order: got %0d items want 1,2,3", seen.size());
    end
  endtask

  task automatic test_stream();
    int outs = 0;
    allow_out = 1'b1;
    for (int i = 0; i < 17; i++) begin
      valid_in = (i < 16);
      in = WIDTH'(i);
      checks++;
      if (valid_out !== (q.size() != 0) || level !== LW'(q.size())) begin
        errors++;
        $display("FAIL stream_level: cyc=%0d valid_out=%b level=%0d want %0d",
                 i, valid_out, level, q.size());
      end else if (valid_out && out !== q[0]) begin
        errors++;
        $display("FAIL stream_data: cyc=%0d out=%h want %h", i, out, q[0]);
      end
      if (i > 0) begin
        checks++;
        if (level !== LW'(1) || out !== WIDTH'(i - 1)) begin
          errors++;
          $display("FAIL stream_rate: cyc=%0d level=%0d out=%h want 1 %h",
                   i, level, out, i - 1);
        end
      end
      if (valid_out) outs++;
      tick();
    end
    valid_in = 1'b0;
    checks++;
    if (outs != 16 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL stream_count: got %0d want 16", outs);
    end
  endtask

  task automatic test_random();
    logic a0;
    for (int i = 0; i < 10000; i++) begin
      valid_in = 1'($urandom_range(0, 1));
      allow_out = 1'($urandom_range(0, 1));
      in = $urandom;
      #1;
      a0 = allow_in;
      allow_out = ~allow_out;
      #1;
      checks++;
      if (allow_in !== a0) begin
        errors++;
        $display("FAIL rand_allow_dep: cyc=%0d allow_in moved %b->%b", i, a0, allow_in);
      end
      allow_out = ~allow_out;
      #1;
      checks++;
      if (level !== LW'(q.size()) || allow_in !== (q.size() != DEPTH) ||
          valid_out !== (q.size() != 0)) begin
        errors++;
        $display("FAIL rand_state: cyc=%0d level=%0d allow_in=%b valid_out=%b want %0d",
                 i, level, allow_in, valid_out, q.size());
      end else if (valid_out && out !== q[0]) begin
        errors++;
        $display("FAIL rand_data: cyc=%0d out=%h want %h", i, out, q[0]);
      end
      tick();
    end
    valid_in = 1'b0;
    allow_out = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_flush();
    allow_out = 1'b0;
    valid_in = 1'b1;
    in = 32'hA1;
    tick();
    in = 32'hA2;
    tick();
    flush = 1'b1;
    allow_out = 1'b1;
    in = 32'hAA;
    tick();
    flush = 1'b0;
    valid_in = 1'b0;
    checks++;
    if (level !== '0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear: level=%0d valid_out=%b want 0 0", level, valid_out);
    end
    valid_in = 1'b1;
    in = 32'h55;
    tick();
    valid_in = 1'b0;
    checks++;
    if (valid_out !== 1'b1 || out !== 32'h55 || level !== LW'(1)) begin
      errors++;
      $display("FAIL flush_after: valid_out=%b out=%h level=%0d want 1 55 1",
               valid_out, out, level);
    end
    tick();
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL flush_stale: valid_out=%b out=%h want 0", valid_out, out);
    end
  endtask

  task automatic test_reset_mid();
    int leaks = 0;
    allow_out = 1'b0;
    valid_in = 1'b1;
    in = 32'h71;
    tick();
    in = 32'h72;
    tick();
    reset = 1'b1;
    in = 32'h77;
    tick();
    reset = 1'b0;
    valid_in = 1'b0;
    checks++;
    if (level !== '0 || valid_out !== 1'b0 || allow_in !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_state: level=%0d valid_out=%b allow_in=%b want 0 0 1",
               level, valid_out, allow_in);
    end
    allow_out = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (valid_out) leaks++;
      tick();
    end
    checks++;
    if (leaks != 0) begin
      errors++;
      $display("FAIL rstmid_leak: got %0d outputs want 0", leaks);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_full();
    test_stream();
    test_random();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
